// File: rtl/pcm_to_i2s.sv
// ---------------------------------------------------------------------------
// pcm_to_i2s
//
// I2S master transmitter. One stereo PCM pair is accepted per frame through a
// valid/ready handshake into a one-entry holding register. At every frame
// boundary the held pair moves into the left/right shift registers and is
// serialized MSB-first, one bit period after each ws edge (I2S one-bit delay).
// The block derives sck and ws from clk with free-running counters.
//
// Optional build macro:
//   PCM_TO_I2S_UNDERRUN_HOLD_EN - when defined, a frame that starts with no
//       sample available retransmits the last successfully loaded pair
//       (zero if none since reset). When undefined, such a frame is all zeros.
//       The underrun pulse is produced in both builds.
//
// Parameters:
//   NUMBER_OF_BITS - PCM word width per channel
//   SLOT_BITS      - bit periods per channel slot (>= NUMBER_OF_BITS+1)
//   CLK_DIV        - clk cycles per bit period (even, >= 2)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_left/in_right hold a sample pair
//   in_ready  out  holding register is empty
//   in_left   in   left sample, two's complement
//   in_right  in   right sample, two's complement
//   sck       out  I2S bit clock (registered)
//   ws        out  word select, 0 = left, 1 = right (registered)
//   sd        out  serial data (registered)
//   underrun  out  one-clk pulse when a frame starts without a sample
// ---------------------------------------------------------------------------
module pcm_to_i2s #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int SLOT_BITS      = 16,
    parameter int CLK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUMBER_OF_BITS-1:0] in_left,
    input  logic [NUMBER_OF_BITS-1:0] in_right,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] RIGHT_BASE = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(NUMBER_OF_BITS);

    typedef logic [NUMBER_OF_BITS-1:0] word_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic             sck_q,      sck_d;
    logic             ws_q,       ws_d;
    logic             sd_q,       sd_d;
    logic             underrun_q, underrun_d;
    logic             hold_full_q, hold_full_d;
    word_t            hold_left_q,  hold_left_d;
    word_t            hold_right_q, hold_right_d;
    word_t            sr_left_q,    sr_left_d;
    word_t            sr_right_q,   sr_right_d;

    // Data sent in a frame that starts with an empty holding register.
    word_t            fill_left;
    word_t            fill_right;

`ifdef PCM_TO_I2S_UNDERRUN_HOLD_EN
    word_t            last_left_q,  last_left_d;
    word_t            last_right_q, last_right_d;

    assign fill_left  = last_left_q;
    assign fill_right = last_right_q;
`else
    assign fill_left  = '0;
    assign fill_right = '0;
`endif

    // ------------------------------------------------------------------
    // Timing counters
    // ------------------------------------------------------------------
    logic div_wrap;
    logic frame_end;

    always_comb begin
        div_wrap  = (div_cnt_q == DIV_LAST);
        frame_end = div_wrap && (bit_cnt_q == BIT_LAST);

        div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);

        bit_cnt_d = bit_cnt_q;
        if (div_wrap) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Position of the bit period being entered (decoded from the next
    // counter value, since sd/ws are registered on the entering edge).
    // ------------------------------------------------------------------
    logic             slot_right;
    logic [BIT_W-1:0] slot_k;
    logic             data_bit;

    always_comb begin
        slot_right = (bit_cnt_d >= RIGHT_BASE);
        slot_k     = slot_right ? (bit_cnt_d - RIGHT_BASE) : bit_cnt_d;
        // k = 0 is the I2S delay bit; k = 1..N carry the word MSB first.
        data_bit   = (slot_k != '0) && (slot_k <= DATA_LAST);
    end

    // ------------------------------------------------------------------
    // Handshake, frame load and serializer
    // ------------------------------------------------------------------
    logic xfer;

    assign xfer = in_valid && !hold_full_q;

    always_comb begin
        hold_full_d  = hold_full_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        sr_left_d    = sr_left_q;
        sr_right_d   = sr_right_q;
        underrun_d   = 1'b0;
        sd_d         = sd_q;
        sck_d        = (div_cnt_d >= DIV_HALF);
        ws_d         = (bit_cnt_d >= RIGHT_BASE);
`ifdef PCM_TO_I2S_UNDERRUN_HOLD_EN
        last_left_d  = last_left_q;
        last_right_d = last_right_q;
`endif

        // Frame load. A pair arriving on this same edge is not bypassed:
        // the load sees the register as empty and the pair waits a frame.
        if (frame_end) begin
            if (hold_full_q) begin
                sr_left_d   = hold_left_q;
                sr_right_d  = hold_right_q;
                hold_full_d = 1'b0;
`ifdef PCM_TO_I2S_UNDERRUN_HOLD_EN
                last_left_d  = hold_left_q;
                last_right_d = hold_right_q;
`endif
            end else begin
                sr_left_d  = fill_left;
                sr_right_d = fill_right;
                underrun_d = 1'b1;
            end
        end

        // xfer implies the register is empty, so it never collides with a
        // successful load on the same edge.
        if (xfer) begin
            hold_full_d  = 1'b1;
            hold_left_d  = in_left;
            hold_right_d = in_right;
        end

        // sd only changes when a new bit period begins (sck falling).
        if (div_wrap) begin
            sd_d = 1'b0;
            if (data_bit) begin
                if (slot_right) begin
                    sd_d       = sr_right_q[NUMBER_OF_BITS-1];
                    sr_right_d = sr_right_q << 1;
                end else begin
                    sd_d       = sr_left_q[NUMBER_OF_BITS-1];
                    sr_left_d  = sr_left_q << 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            sck_q        <= 1'b0;
            ws_q         <= 1'b0;
            sd_q         <= 1'b0;
            underrun_q   <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            sr_left_q    <= '0;
            sr_right_q   <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sck_q        <= sck_d;
            ws_q         <= ws_d;
            sd_q         <= sd_d;
            underrun_q   <= underrun_d;
            hold_full_q  <= hold_full_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            sr_left_q    <= sr_left_d;
            sr_right_q   <= sr_right_d;
        end
    end

`ifdef PCM_TO_I2S_UNDERRUN_HOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_left_q  <= '0;
            last_right_q <= '0;
        end else begin
            last_left_q  <= last_left_d;
            last_right_q <= last_right_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready = !hold_full_q;
    assign sck      = sck_q;
    assign ws       = ws_q;
    assign sd       = sd_q;
    assign underrun = underrun_q;

endmodule
